// File: rtl/fc_argmax_stream_pkg.sv
// Shared types and geometry helpers for the streaming argmax classifier tail.
// IDX_W/BEATS describe the default geometry; parametrised users call the functions.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fc_argmax_state_t;

  function automatic int idx_w(input int layer_size);
    return (layer_size > 1) ? $clog2(layer_size) : 1;
  endfunction

  function automatic int beats(input int layer_size, input int lanes);
    return layer_size / lanes;
  endfunction

  localparam int FC_LAYER_SIZE = 10;
  localparam int FC_LANES      = 1;
  localparam int IDX_W         = idx_w(FC_LAYER_SIZE);
  localparam int BEATS         = beats(FC_LAYER_SIZE, FC_LANES);

endpackage

// File: rtl/fc_argmax_stream_node.sv
// One argmax comparator: picks the larger (value, index) pair, lower index on ties.
module fc_argmax_node #(
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = 4,
  parameter bit SIGNED    = 1'b1
) (
  input  logic [WORD_SIZE-1:0] i_a_val,
  input  logic [IDX_W-1:0]     i_a_idx,
  input  logic [WORD_SIZE-1:0] i_b_val,
  input  logic [IDX_W-1:0]     i_b_idx,
  output logic [WORD_SIZE-1:0] o_val,
  output logic [IDX_W-1:0]     o_idx
);

  logic signed [WORD_SIZE-1:0] w_a_s;
  logic signed [WORD_SIZE-1:0] w_b_s;
  logic                        w_gt;
  logic                        w_b_wins;

  assign w_a_s = $signed(i_a_val);
  assign w_b_s = $signed(i_b_val);

  always_comb begin
    if (SIGNED) w_gt = (w_b_s > w_a_s);
    else        w_gt = (i_b_val > i_a_val);
  end

  assign w_b_wins = w_gt || ((i_b_val == i_a_val) && (i_b_idx < i_a_idx));
  assign o_val    = w_b_wins ? i_b_val : i_a_val;
  assign o_idx    = w_b_wins ? i_b_idx : i_a_idx;

endmodule

// File: rtl/fc_argmax_stream.sv
// Streaming argmax over LAYER_SIZE scores arriving LANES per beat; the winning
// index/score is held on a registered valid/ready output until consumed.
module fc_argmax_stream
  import fc_pkg::*;
#(
  parameter int WORD_SIZE  = 16,
  parameter int LAYER_SIZE = FC_LAYER_SIZE,
  parameter int LANES      = FC_LANES,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_SIZE-1:0]          in_data [LANES],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(LAYER_SIZE)-1:0] out_idx,
  output logic [WORD_SIZE-1:0]          out_val
);

  localparam int AW = $clog2(LAYER_SIZE);
  localparam int NB = beats(LAYER_SIZE, LANES);
  localparam int CW = idx_w(NB);
  localparam int D  = $clog2(LANES);
  localparam int P  = 1 << D;

  if (LAYER_SIZE % LANES != 0) begin : g_bad_geometry
    $error("fc_argmax_stream: LAYER_SIZE must be a multiple of LANES");
  end

  fc_argmax_state_t    r_state;
  logic [CW-1:0]        r_beat_cnt;
  logic [WORD_SIZE-1:0] r_acc_val;
  logic [AW-1:0]        r_acc_idx;
  logic [WORD_SIZE-1:0] r_out_val;
  logic [AW-1:0]        r_out_idx;

  logic [WORD_SIZE-1:0] w_red_val;
  logic [AW-1:0]        w_red_idx;
  logic [WORD_SIZE-1:0] w_win_val;
  logic [AW-1:0]        w_win_idx;
  logic [WORD_SIZE-1:0] w_pick_val;
  logic [AW-1:0]        w_pick_idx;
  logic                 w_last;

  // Lane reduction tree; missing leaves of a non-power-of-two width mirror lane 0,
  // which can never change the result.
  for (genvar lv = 0; lv <= D; lv++) begin : g_lvl
    logic [WORD_SIZE-1:0] w_val [P >> lv];
    logic [AW-1:0]        w_idx [P >> lv];
    for (genvar n = 0; n < (P >> lv); n++) begin : g_n
      if (lv == 0) begin : g_leaf
        localparam int L = (n < LANES) ? n : 0;
        assign w_val[n] = in_data[L];
        assign w_idx[n] = AW'(int'(r_beat_cnt) * LANES + L);
      end else begin : g_cmp
        fc_argmax_node #(.WORD_SIZE(WORD_SIZE), .IDX_W(AW), .SIGNED(SIGNED)) u_node (
          .i_a_val(g_lvl[lv-1].w_val[2*n]),
          .i_a_idx(g_lvl[lv-1].w_idx[2*n]),
          .i_b_val(g_lvl[lv-1].w_val[2*n+1]),
          .i_b_idx(g_lvl[lv-1].w_idx[2*n+1]),
          .o_val  (w_val[n]),
          .o_idx  (w_idx[n])
        );
      end
    end
  end

  assign w_red_val = g_lvl[D].w_val[0];
  assign w_red_idx = g_lvl[D].w_idx[0];

  fc_argmax_node #(.WORD_SIZE(WORD_SIZE), .IDX_W(AW), .SIGNED(SIGNED)) u_acc_node (
    .i_a_val(r_acc_val),
    .i_a_idx(r_acc_idx),
    .i_b_val(w_red_val),
    .i_b_idx(w_red_idx),
    .o_val  (w_win_val),
    .o_idx  (w_win_idx)
  );

  assign w_pick_val = (r_state == IDLE) ? w_red_val : w_win_val;
  assign w_pick_idx = (r_state == IDLE) ? w_red_idx : w_win_idx;
  assign w_last     = (r_beat_cnt == CW'(NB - 1));

  assign in_ready  = (r_state != DONE);
  assign out_valid = (r_state == DONE);
  assign out_idx   = r_out_idx;
  assign out_val   = r_out_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_beat_cnt <= '0;
      r_acc_val  <= '0;
      r_acc_idx  <= '0;
      r_out_val  <= '0;
      r_out_idx  <= '0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          // A flush wins over a beat offered in the same cycle.
          if (flush) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
          end else if (in_valid) begin
            r_acc_val <= w_pick_val;
            r_acc_idx <= w_pick_idx;
            if (w_last) begin
              r_state    <= DONE;
              r_beat_cnt <= '0;
              r_out_val  <= w_pick_val;
              r_out_idx  <= w_pick_idx;
            end else begin
              r_state    <= ACCUM;
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fc_argmax_stream.md
# fc_argmax_stream

Sequential, parametrised argmax unit that closes the fully-connected classifier. It accepts the output-layer scores as a valid/ready stream, `LANES` scores per beat. It tracks the running maximum and its index across `LAYER_SIZE` scores, then presents the winning class index and score on a registered, handshaked output. It replaces the purely combinational comparator chain: it supports signed or unsigned scores, multi-lane beats and deterministic tie-breaking.

## Interface
- `WORD_SIZE`, 16, score width in bits.
- `LAYER_SIZE`, 10, scores per classification; must be a multiple of `LANES`.
- `LANES`, 1, scores per input beat.
- `SIGNED`, 1, 1 = two's-complement compare, 0 = unsigned compare.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the classification in progress.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  `WORD_SIZE` x `LANES` (unpacked array)  scores; lane j holds element `beat*LANES + j`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_idx`  out  `$clog2(LAYER_SIZE)`  winning class index.
- `out_val`  out  `WORD_SIZE`  winning score.

## Operation
- States:
  - IDLE: no beat accepted yet. `in_ready`=1.
  - ACCUM: at least one beat accepted, more expected. `in_ready`=1.
  - DONE: result held. `in_ready`=0, `out_valid`=1.
- A beat transfers when `in_valid && in_ready`.
- Intra-beat: the lanes are reduced to one (value, index) pair. Index = `beat_cnt*LANES + lane`.
- First beat: the reduced pair is loaded directly into the accumulator registers (`acc_val`, `acc_idx`).
- Later beats: the reduced pair replaces the accumulator only if it is strictly greater.
- Tie rule everywhere (lanes and beats): the lower index wins.
- Compare: signed when `SIGNED`=1 (0x8000 < 0x0001), unsigned otherwise.
- `beat_cnt` runs 0..`LAYER_SIZE/LANES`-1.
  - Accepting beat 0 moves IDLE to ACCUM. If `LAYER_SIZE==LANES`, it goes straight to DONE.
  - Accepting the last beat moves to DONE and loads `out_idx`/`out_val` from the final comparison.
  - `beat_cnt` wraps to 0 on entry to DONE.
- DONE to IDLE on `out_valid && out_ready`. Outputs hold their values until the next result.
- `flush`:
  - In IDLE or ACCUM: go to IDLE and clear `beat_cnt`. A beat presented that same cycle is dropped.
  - In DONE: ignored, so a completed result is never lost.
- Reset values: state IDLE, `beat_cnt` 0, `out_valid` 0, `out_idx` 0, `out_val` 0, accumulator 0. `in_ready` is 1 after reset.
- Asserting `rst_n` low mid-classification discards everything immediately; no partial result is emitted.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from any input to either.
- Latency: `out_valid` rises on the clock edge that accepts the last beat. The result is visible the cycle after that handshake.
- Throughput: one beat per cycle in ACCUM. One idle cycle per classification, because `in_ready` returns only the cycle after the output handshake.
- `out_valid` held with `out_ready` low: `out_idx`/`out_val` stay stable indefinitely.
- Lane reduction tree depth is `$clog2(LANES)` comparator levels. No internal pipelining.

## Structure
- Shared package `fc_pkg`:
  - `fc_argmax_state_t` enum (IDLE, ACCUM, DONE).
  - `localparam` helpers `IDX_W = $clog2(LAYER_SIZE)` and `BEATS = LAYER_SIZE/LANES`.
- Sub-module `fc_argmax_node`: parametrised on `WORD_SIZE`, `IDX_W`, `SIGNED`.
  - Takes two (value, index) pairs and returns the winner per the compare and tie rules.
  - Instantiated in a generate tree for the lanes, plus once for accumulator vs lane result.
- Elaboration assertion: `LAYER_SIZE % LANES == 0`.

## Test plan
- Defaults (LANES=1, SIGNED=1), scores 3,-5,7,2,7,0,-1,6,1,4 streamed back-to-back:
  - `out_valid` appears 1 cycle after the 10th beat, with `out_idx`=2, `out_val`=7.
  - This also checks the tie rule.
- SIGNED=1, all ten scores 0x8000 except index 9 = 0x8001:
  - Expect `out_idx`=9.
  - Same data with SIGNED=0, index 9 = 0x0001: expect `out_idx`=0.
- LANES=5, beats {1,9,9,0,2} and {9,3,4,4,4}:
  - Expect `out_idx`=1, `out_val`=9.
  - Result valid after exactly 2 accepted beats.
- Backpressure:
  - Hold `out_ready`=0 for 20 cycles. Outputs stay stable, `in_ready`=0, and offered beats are not consumed.
  - Then `out_ready`=1: next classification starts 1 cycle later.
- Random `in_valid` gaps, plus `flush` after beat 4 followed by a full new vector:
  - Result reflects only the new vector.
- `rst_n` pulsed low after beat 6:
  - Outputs return to 0 asynchronously and `out_valid` stays 0.
  - The next 10 beats give a correct result.
